// File: rtl/health_alert_dispatcher.sv
// health_alert_dispatcher: pages pending severity codes highest-first over req/ack, retrying and escalating on silence
module health_alert_dispatcher #(
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3,
    parameter int HOLDOFF     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] warningCode,
    input  logic       pagerAck,
    input  logic       clearEmergency,
    output logic       pagerReq,
    output logic [2:0] pagerCode,
    output logic       emergencyCall,
    output logic [2:0] emergencyCode,
    output logic [6:0] pendingMask,
    output logic       busy
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int AW = $clog2(MAX_RETRY + 1);
    localparam int GW = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP, GAP} stateType;

    stateType state, nextState;
    logic [2:0]    prevCode, topCode;
    logic [6:0]    setMask, clrMask;
    logic [TW-1:0] timer;
    logic [AW-1:0] attempt;
    logic [GW-1:0] gapCnt;
    logic          timeout, lastTry, gapDone, escalate, select;

    always_comb begin
        topCode = '0;
        for (int i = 0; i < 7; i++)
            if (pendingMask[i]) topCode = 3'(i + 1);
    end

    assign timeout  = timer == TW'(ACK_TIMEOUT - 1);
    assign lastTry  = attempt == AW'(MAX_RETRY - 1);
    assign gapDone  = gapCnt == GW'(HOLDOFF - 1);
    assign select   = state == IDLE && topCode != 3'd0;
    assign escalate = state == REQ && !pagerAck && timeout && lastTry;
    assign setMask  = (warningCode != 3'd0 && warningCode != prevCode) ? 7'(1) << (warningCode - 3'd1) : '0;
    assign clrMask  = select ? 7'(1) << (topCode - 3'd1) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = select ? REQ : IDLE;
            REQ:     nextState = pagerAck ? GAP : !timeout ? REQ : lastTry ? GAP : DROP;
            DROP:    nextState = REQ;
            default: nextState = gapDone ? IDLE : GAP;
        endcase
    end

    always_comb begin
        pagerReq = state == REQ;
        busy     = state != IDLE;
    end

    // Capture set is applied after the selection clear, so a re-posted in-flight level survives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prevCode      <= '0;
            pendingMask   <= '0;
            pagerCode     <= '0;
            timer         <= '0;
            attempt       <= '0;
            gapCnt        <= '0;
            emergencyCall <= 1'b0;
            emergencyCode <= '0;
        end else begin
            prevCode      <= warningCode;
            pendingMask   <= (pendingMask & ~clrMask) | setMask;
            pagerCode     <= select ? topCode : pagerCode;
            timer         <= (state == REQ && !pagerAck && !timeout) ? timer + 1'b1 : '0;
            attempt       <= state == IDLE ? '0 : (state == REQ && !pagerAck && timeout) ? attempt + 1'b1 : attempt;
            gapCnt        <= state == GAP ? gapCnt + 1'b1 : '0;
            emergencyCall <= escalate | (emergencyCall & ~clearEmergency);
            emergencyCode <= escalate ? pagerCode : emergencyCode;
        end
    end
endmodule
